rs_issue_queue: RTL

- Reservation-station issue queue; the issuing end of the FU_IF handshake. It drives the RS modport signals toward NUM_OF_FU functional units.
- Holds renamed instructions from dispatch and wakes up source operands from the CDB broadcast.
- Selects operand-complete entries and issues them to FUs with a valid/ready handshake.
- Sits between rename/dispatch and the FU array.

---
 rtl/rs_issue_queue_pkg.sv | 58 +++++
 rtl/rs_select.sv | 36 +++
 rtl/rs_issue_queue.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/rs_issue_queue_pkg.sv
// Shared types for the reservation-station issue queue.
//   - Default datapath widths (only defined if the surrounding codebase has not already done so).
//   - control_t  : decoded control bundle carried alongside each instruction.
//   - rs_entry_t : one reservation-station slot (state bits, source tags/values, payload).
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 5
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

package rs_issue_queue_pkg;

   localparam int unsigned RegValW = `REG_VAL_WIDTH;
   localparam int unsigned PregW   = `PHYSICAL_REG_NUM_WIDTH;
   localparam int unsigned RobW    = `ROB_SIZE_WIDTH;
   localparam int unsigned PcW     = `INST_ADDR_WIDTH;

   typedef enum logic [2:0] {
      AluAdd,
      AluSub,
      AluAnd,
      AluOr,
      AluXor,
      AluSll,
      AluSrl,
      AluSlt
   } alu_op_e;

   typedef struct packed {
      alu_op_e alu_op;
      logic    use_imm;
      logic    is_branch;
      logic    is_mem;
   } control_t;

   typedef struct packed {
      logic               busy;
      logic               src1_rdy;
      logic               src2_rdy;
      logic [PregW-1:0]   src1_tag;
      logic [PregW-1:0]   src2_tag;
      logic [RegValW-1:0] src1_val;
      logic [RegValW-1:0] src2_val;
      logic [PregW-1:0]   dst;
      control_t           control;
      logic [RegValW-1:0] imm;
      logic [PcW-1:0]     pc;
      logic [RobW-1:0]    rob_tag;
   } rs_entry_t;

endpackage

// File: rtl/rs_select.sv
// Combinational picker: returns the first NumGnt set bits of req_i, lowest index first.
//   req_i   : request vector (eligible entries)
//   gnt_o   : per-grant one-hot index into req_i (all-zero when no k-th request exists)
//   valid_o : grant k is populated
module rs_select #(
   parameter int unsigned NumReq = 8,
   parameter int unsigned NumGnt = 2
) (
   input  logic [NumReq-1:0]             req_i,
   output logic [NumGnt-1:0][NumReq-1:0] gnt_o,
   output logic [NumGnt-1:0]             valid_o
);

   logic [NumReq-1:0] remain;
   logic              found;

   // Each stage grabs the lowest remaining request, then masks it out for the next stage.
   always_comb begin
      remain  = req_i;
      gnt_o   = '0;
      valid_o = '0;
      found   = 1'b0;
      for (int k = 0; k < NumGnt; k++) begin
         found = 1'b0;
         for (int i = 0; i < NumReq; i++) begin
            if (remain[i] && !found) begin
               gnt_o[k][i] = 1'b1;
               found       = 1'b1;
            end
         end
         valid_o[k] = found;
         remain     = remain & ~gnt_o[k];
      end
   end

endmodule

// File: rtl/rs_issue_queue.sv
// Reservation-station issue queue: accepts renamed instructions from dispatch, wakes source
// operands from the CDB, and issues operand-complete entries to NUM_OF_FU functional units.
//   clk, reset (sync, active-high), flush : control
//   disp_*    : dispatch request/payload, disp_ready when a slot is free
//   cdb_*     : result broadcast used for wakeup (and dispatch bypass)
//   fu_*      : per-port issue valid/ready handshake and payload
//   occupancy : number of busy entries
module rs_issue_queue
   import rs_issue_queue_pkg::*;
#(
   parameter int unsigned RS_DEPTH      = 8,
   parameter int unsigned NUM_OF_FU     = 2,
   parameter int unsigned REG_VAL_WIDTH = RegValW,
   parameter int unsigned PREG_W        = PregW,
   parameter int unsigned ROB_W         = RobW,
   parameter int unsigned PC_W          = PcW
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic                                    flush,
   input  logic                                    disp_valid,
   output logic                                    disp_ready,
   input  logic                                    disp_src1_rdy,
   input  logic                                    disp_src2_rdy,
   input  logic [PREG_W-1:0]                       disp_src1_tag,
   input  logic [PREG_W-1:0]                       disp_src2_tag,
   input  logic [REG_VAL_WIDTH-1:0]                disp_src1_val,
   input  logic [REG_VAL_WIDTH-1:0]                disp_src2_val,
   input  logic [PREG_W-1:0]                       disp_dst,
   input  control_t                                disp_control,
   input  logic [REG_VAL_WIDTH-1:0]                disp_imm,
   input  logic [PC_W-1:0]                         disp_pc,
   input  logic [ROB_W-1:0]                        disp_rob_tag,
   input  logic                                    cdb_valid,
   input  logic [PREG_W-1:0]                       cdb_tag,
   input  logic [REG_VAL_WIDTH-1:0]                cdb_val,
   input  logic [NUM_OF_FU-1:0]                    fu_ready,
   output logic [NUM_OF_FU-1:0]                    fu_valid,
   output logic [NUM_OF_FU-1:0][REG_VAL_WIDTH-1:0] fu_src1_val,
   output logic [NUM_OF_FU-1:0][REG_VAL_WIDTH-1:0] fu_src2_val,
   output logic [NUM_OF_FU-1:0][PREG_W-1:0]        fu_dst,
   output control_t [NUM_OF_FU-1:0]                fu_control,
   output logic [NUM_OF_FU-1:0][REG_VAL_WIDTH-1:0] fu_imm,
   output logic [NUM_OF_FU-1:0][PC_W-1:0]          fu_pc,
   output logic [NUM_OF_FU-1:0][ROB_W-1:0]         fu_rob_tag,
   output logic [$clog2(RS_DEPTH):0]               occupancy
);

   localparam int unsigned IdxW = $clog2(RS_DEPTH);
   localparam int unsigned CntW = IdxW + 1;

   rs_entry_t entries_q [RS_DEPTH];
   rs_entry_t entries_d [RS_DEPTH];

   logic [RS_DEPTH-1:0]                busy;
   logic [RS_DEPTH-1:0]                eligible;
   logic [NUM_OF_FU-1:0][RS_DEPTH-1:0] sel_oh;
   logic [NUM_OF_FU-1:0]               sel_valid;
   logic [IdxW-1:0]                    free_idx;
   logic                               free_found;
   logic                               disp_fire;
   rs_entry_t                          new_entry;

   always_comb begin
      busy      = '0;
      eligible  = '0;
      occupancy = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         busy[i]     = entries_q[i].busy;
         eligible[i] = entries_q[i].busy && entries_q[i].src1_rdy && entries_q[i].src2_rdy;
         occupancy   = occupancy + {{(CntW-1){1'b0}}, entries_q[i].busy};
      end
   end

   // Registered state only: a slot freed by this cycle's issue is not offered to dispatch.
   assign disp_ready = (occupancy < CntW'(RS_DEPTH));
   assign disp_fire  = disp_valid && disp_ready;

   always_comb begin
      free_idx   = '0;
      free_found = 1'b0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         if (!busy[i] && !free_found) begin
            free_idx   = IdxW'(i);
            free_found = 1'b1;
         end
      end
   end

   // Incoming entry, with same-cycle CDB bypass for sources that are still pending.
   always_comb begin
      new_entry          = '0;
      new_entry.busy     = 1'b1;
      new_entry.src1_rdy = disp_src1_rdy;
      new_entry.src2_rdy = disp_src2_rdy;
      new_entry.src1_tag = disp_src1_tag;
      new_entry.src2_tag = disp_src2_tag;
      new_entry.src1_val = disp_src1_val;
      new_entry.src2_val = disp_src2_val;
      new_entry.dst      = disp_dst;
      new_entry.control  = disp_control;
      new_entry.imm      = disp_imm;
      new_entry.pc       = disp_pc;
      new_entry.rob_tag  = disp_rob_tag;
      if (cdb_valid && !disp_src1_rdy && (disp_src1_tag == cdb_tag)) begin
         new_entry.src1_rdy = 1'b1;
         new_entry.src1_val = cdb_val;
      end
      if (cdb_valid && !disp_src2_rdy && (disp_src2_tag == cdb_tag)) begin
         new_entry.src2_rdy = 1'b1;
         new_entry.src2_val = cdb_val;
      end
   end

   rs_select #(
      .NumReq (RS_DEPTH),
      .NumGnt (NUM_OF_FU)
   ) u_select (
      .req_i   (eligible),
      .gnt_o   (sel_oh),
      .valid_o (sel_valid)
   );

   always_comb begin
      for (int i = 0; i < RS_DEPTH; i++) begin
         entries_d[i] = entries_q[i];
         if (entries_q[i].busy && cdb_valid) begin
            if (!entries_q[i].src1_rdy && (entries_q[i].src1_tag == cdb_tag)) begin
               entries_d[i].src1_rdy = 1'b1;
               entries_d[i].src1_val = cdb_val;
            end
            if (!entries_q[i].src2_rdy && (entries_q[i].src2_tag == cdb_tag)) begin
               entries_d[i].src2_rdy = 1'b1;
               entries_d[i].src2_val = cdb_val;
            end
         end
      end
      for (int k = 0; k < NUM_OF_FU; k++) begin
         if (sel_valid[k] && fu_ready[k]) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
               if (sel_oh[k][i]) begin
                  entries_d[i].busy = 1'b0;
               end
            end
         end
      end
      if (disp_fire) begin
         entries_d[free_idx] = new_entry;
      end
      if (flush) begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            entries_d[i].busy = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            entries_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            entries_q[i] <= entries_d[i];
         end
      end
   end

   // One-hot mux per port; payload is zero whenever the port has no selected entry.
   always_comb begin
      fu_valid    = sel_valid;
      fu_src1_val = '0;
      fu_src2_val = '0;
      fu_dst      = '0;
      fu_control  = '0;
      fu_imm      = '0;
      fu_pc       = '0;
      fu_rob_tag  = '0;
      for (int k = 0; k < NUM_OF_FU; k++) begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            if (sel_oh[k][i]) begin
               fu_src1_val[k] = entries_q[i].src1_val;
               fu_src2_val[k] = entries_q[i].src2_val;
               fu_dst[k]      = entries_q[i].dst;
               fu_control[k]  = entries_q[i].control;
               fu_imm[k]      = entries_q[i].imm;
               fu_pc[k]       = entries_q[i].pc;
               fu_rob_tag[k]  = entries_q[i].rob_tag;
            end
         end
      end
   end

endmodule
